// File: rtl/axis_frame_sequencer_pkg.sv
// Shared types and constants for the AXIS frame sequencer.
//  state_t     : sequencer state (IDLE, ARM, RUN, GAP), 2-bit encoding
//  ARM_CYCLES  : cycles spent in ARM so the writer's registered length settles
package axis_frame_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2,
      GAP  = 2'd3
   } state_t;

   localparam int unsigned ARM_CYCLES = 2;

endpackage

// File: rtl/axis_frame_seq_gap_cntr.sv
// Loadable down counter with a zero flag; times both the ARM settle window
// and the inter-frame idle gap.
//  clk_i      : clock
//  rst_i      : synchronous active-high reset
//  load_i     : load load_val_i (takes priority over dec_i)
//  load_val_i : value to load (number of wait cycles minus one)
//  dec_i      : decrement, holds at zero
//  zero_o     : counter is zero (decoded from the count register)
module axis_frame_seq_gap_cntr #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [WIDTH-1:0] cnt_q;

   // Count register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - WIDTH'(1);
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/axis_frame_sequencer.sv
// Frame sequencer in front of the counter-tagging AXIS writer. Runs a number
// of frames of (cfg_length+1) words, gates the sample stream into the writer,
// supplies the writer's length and frame-index tag, inserts an idle gap
// between frames and reports progress.
// Optional feature macro: FRAME_TLAST_EN adds m_axis_tlast on the final beat
// of each frame.
//  aclk, areset        : clock, synchronous active-high reset
//  cfg_start           : rising edge starts a run (dropped while busy)
//  cfg_abort           : level, stops at the next frame boundary
//  cfg_length          : words per frame minus one
//  cfg_frames          : frames per run, 0 = continuous
//  cfg_gap             : idle cycles between frames
//  wr_cfg_data         : latched length to the writer
//  wr_misc_data        : current frame index, tag to the writer
//  s_axis_*            : upstream sample stream
//  m_axis_*            : stream to the writer (tdata passes straight through)
//  m_axis_tlast        : final beat of a frame (FRAME_TLAST_EN only)
//  sts_busy            : not IDLE
//  sts_frames          : completed frames in the current/last run
module axis_frame_sequencer
   import axis_frame_sequencer_pkg::*;
#(
   parameter int unsigned AXIS_TDATA_WIDTH = 32,
   parameter int unsigned CNTR_WIDTH       = 16,
   parameter int unsigned FRAM_WIDTH       = 16,
   parameter int unsigned GAP_WIDTH        = 16
) (
   input  logic                        aclk,
   input  logic                        areset,
   input  logic                        cfg_start,
   input  logic                        cfg_abort,
   input  logic [CNTR_WIDTH-1:0]       cfg_length,
   input  logic [FRAM_WIDTH-1:0]       cfg_frames,
   input  logic [GAP_WIDTH-1:0]        cfg_gap,
   output logic [CNTR_WIDTH-1:0]       wr_cfg_data,
   output logic [FRAM_WIDTH-1:0]       wr_misc_data,
   output logic                        s_axis_tready,
   input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic                        s_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                        m_axis_tvalid,
`ifdef FRAME_TLAST_EN
   output logic                        m_axis_tlast,
`endif
   output logic                        sts_busy,
   output logic [FRAM_WIDTH-1:0]       sts_frames
);

   state_t                  state_q;
   logic                    cfg_start_q;
   logic [CNTR_WIDTH-1:0]   length_q;
   logic [FRAM_WIDTH-1:0]   frames_q;
   logic [GAP_WIDTH-1:0]    gap_q;
   logic [CNTR_WIDTH-1:0]   word_cnt_q;
   logic [FRAM_WIDTH-1:0]   frame_idx_q;
   logic [FRAM_WIDTH-1:0]   done_cnt_q;

   logic                    start_edge;
   logic                    start_go;
   logic                    in_run;
   logic                    beat;
   logic                    last_word;
   logic                    frame_end;
   logic                    run_done;
   logic                    stop_at_end;
   logic                    wait_ld;
   logic [GAP_WIDTH-1:0]    wait_ld_val;
   logic                    wait_dec;
   logic                    wait_zero;

   // Handshake and frame-boundary decode
   assign start_edge  = cfg_start & ~cfg_start_q;
   assign start_go    = start_edge & ~cfg_abort;
   assign in_run      = (state_q == RUN);
   assign beat        = in_run & s_axis_tvalid & m_axis_tready;
   // Equality compare so an all-ones length gives 2^CNTR_WIDTH words
   assign last_word   = (word_cnt_q == length_q);
   assign frame_end   = beat & last_word;
   assign run_done    = (frames_q != '0) && ((done_cnt_q + FRAM_WIDTH'(1)) == frames_q);
   assign stop_at_end = run_done | cfg_abort;

   // Wait counter control: ARM and GAP share one down counter
   always_comb begin
      wait_ld     = 1'b0;
      wait_ld_val = '0;
      wait_dec    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_go) begin
               wait_ld     = 1'b1;
               wait_ld_val = GAP_WIDTH'(ARM_CYCLES - 1);
            end
         end
         RUN: begin
            if (frame_end && !stop_at_end && (gap_q != '0)) begin
               wait_ld     = 1'b1;
               wait_ld_val = gap_q - GAP_WIDTH'(1);
            end
         end
         ARM, GAP: wait_dec = 1'b1;
         default: ;
      endcase
   end

   axis_frame_seq_gap_cntr #(
      .WIDTH (GAP_WIDTH)
   ) u_wait_cntr (
      .clk_i      (aclk),
      .rst_i      (areset),
      .load_i     (wait_ld),
      .load_val_i (wait_ld_val),
      .dec_i      (wait_dec),
      .zero_o     (wait_zero)
   );

   // Sequencer FSM, configuration latch and frame/word counters
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q     <= IDLE;
         cfg_start_q <= 1'b0;
         length_q    <= '0;
         frames_q    <= '0;
         gap_q       <= '0;
         word_cnt_q  <= '0;
         frame_idx_q <= '0;
         done_cnt_q  <= '0;
      end else begin
         cfg_start_q <= cfg_start;
         case (state_q)
            IDLE: begin
               if (start_go) begin
                  state_q     <= ARM;
                  length_q    <= cfg_length;
                  frames_q    <= cfg_frames;
                  gap_q       <= cfg_gap;
                  word_cnt_q  <= '0;
                  frame_idx_q <= '0;
                  done_cnt_q  <= '0;
               end
            end
            ARM: begin
               if (cfg_abort) begin
                  state_q <= IDLE;
               end else if (wait_zero) begin
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (frame_end) begin
                  word_cnt_q  <= '0;
                  done_cnt_q  <= done_cnt_q + FRAM_WIDTH'(1);
                  frame_idx_q <= frame_idx_q + FRAM_WIDTH'(1);
                  // Abort only acts here so a frame is never cut short
                  if (stop_at_end) begin
                     state_q <= IDLE;
                  end else if (gap_q != '0) begin
                     state_q <= GAP;
                  end
               end else if (beat) begin
                  word_cnt_q <= word_cnt_q + CNTR_WIDTH'(1);
               end
            end
            GAP: begin
               if (cfg_abort) begin
                  state_q <= IDLE;
               end else if (wait_zero) begin
                  state_q <= RUN;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Stream gating: pass-through with zero latency while in RUN
   assign m_axis_tdata  = s_axis_tdata;
   assign m_axis_tvalid = in_run & s_axis_tvalid;
   assign s_axis_tready = in_run & m_axis_tready;

`ifdef FRAME_TLAST_EN
   assign m_axis_tlast  = in_run & last_word;
`endif

   assign wr_cfg_data  = length_q;
   assign wr_misc_data = frame_idx_q;
   assign sts_frames   = done_cnt_q;
   assign sts_busy     = (state_q != IDLE);

endmodule
